// File: rtl/prng_lane_adder.sv
// prng_lane_adder
// Job-counted, two-stage pipelined 256-bit SIMD adder sitting on the PRNG
// output stream. Each job adds num operand pairs lane-wise. The lane width
// is selected per job. Exactly num results are emitted, followed by a
// one-cycle done_o pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; the job width and length are latched here
// RUN   | accepting operands and emitting sums until num results are out
// DONE  | single-cycle job-end marker; done_o is high
module prng_lane_adder #(
    parameter int LEN_W   = 256,
    parameter int LEN_CNT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [2:0]         width_i,
    input  logic [LEN_CNT-1:0] num_i,
    input  logic [LEN_W-1:0]   a_i,
    input  logic [LEN_W-1:0]   b_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [LEN_W-1:0]   sum_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int LIMB_W = 32;
    localparam int N_LIMB = LEN_W / LIMB_W;
    localparam logic [LEN_CNT-1:0] CNT_ONE = LEN_CNT'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-limb 32-bit sum with its carry (generate) bit.
    typedef struct packed {
        logic              c;
        logic [LIMB_W-1:0] v;
    } u32_w_c_t;

    // Carry-kill bit for each limb. The full-width mask has one bit per limb
    // at position 32k; this compact form holds bit k for limb k.
    // width encoding is {is256, is128, is64}; limb 0 never takes a carry in.
    function automatic logic [N_LIMB-1:0] make_carry_mask(input logic [2:0] w);
        logic [N_LIMB-1:0] m;
        m = '0;
        for (int k = 0; k < N_LIMB; k++) begin
            if (k == 0) begin
                m[k] = 1'b1;
            end else if ((k % 2) == 1) begin
                m[k] = !w[0];
            end else if ((k % 4) == 2) begin
                m[k] = !w[1];
            end else begin
                m[k] = !w[2];
            end
        end
        return m;
    endfunction

    state_t state_q, state_d;

    logic [2:0]         width_q;
    logic [LEN_CNT-1:0] num_q;
    logic [LEN_CNT-1:0] in_cnt_q;
    logic [LEN_CNT-1:0] out_cnt_q;

    logic adv;
    logic in_hs;
    logic out_hs;
    logic job_start;

    // Stage 1: per-limb sums, generate and propagate flags
    logic                          s1_vld_q;
    logic [N_LIMB-1:0]             g_q, p_q;
    logic [N_LIMB-1:0][LIMB_W-1:0] v_q;
    logic [N_LIMB-1:0]             g_nxt, p_nxt;
    logic [N_LIMB-1:0][LIMB_W-1:0] v_nxt;
    u32_w_c_t                      limb_sum;

    // Stage 2: carry resolution into the output register
    logic [N_LIMB-1:0] kill;
    logic [LEN_W-1:0]  sum_nxt;
    logic              carry;
    logic              carry_in;
    logic              out_valid_q;
    logic [LEN_W-1:0]  sum_q;

    assign adv       = !out_valid_q || out_ready_i;
    assign in_hs     = in_valid_i && in_ready_o;
    assign out_hs    = out_valid_q && out_ready_i;
    assign job_start = (state_q == ST_IDLE) && start_i;

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        state_d    = state_q;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        in_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (num_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o     = 1'b1;
                in_ready_o = (in_cnt_q < num_q) && adv;
                if (out_hs && ((out_cnt_q + CNT_ONE) == num_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Job configuration latch and input/output handshake counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width_q   <= '0;
            num_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (job_start) begin
            width_q   <= width_i;
            num_q     <= num_i;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (in_hs) begin
                in_cnt_q <= in_cnt_q + CNT_ONE;
            end
            if (out_hs) begin
                out_cnt_q <= out_cnt_q + CNT_ONE;
            end
        end
    end

    // Stage 1 combinational: independent 32-bit limb adds
    always_comb begin
        g_nxt    = '0;
        p_nxt    = '0;
        v_nxt    = '0;
        limb_sum = '0;
        for (int k = 0; k < N_LIMB; k++) begin
            limb_sum = {1'b0, a_i[LIMB_W*k +: LIMB_W]} + {1'b0, b_i[LIMB_W*k +: LIMB_W]};
            g_nxt[k] = limb_sum.c;
            v_nxt[k] = limb_sum.v;
            p_nxt[k] = (limb_sum.v == {LIMB_W{1'b1}});
        end
    end

    // Stage 2 combinational: ripple limb carries, cut at lane boundaries.
    // The carry leaving the top limb of each lane is dropped by the kill bit
    // of the next limb, and the carry out of limb 7 is simply not used.
    always_comb begin
        kill     = make_carry_mask(width_q);
        sum_nxt  = '0;
        carry    = 1'b0;
        carry_in = 1'b0;
        for (int k = 0; k < N_LIMB; k++) begin
            carry_in = carry && !kill[k];
            sum_nxt[LIMB_W*k +: LIMB_W] = v_q[k] + {{(LIMB_W-1){1'b0}}, carry_in};
            carry = g_q[k] || (p_q[k] && carry_in);
        end
    end

    // Pipeline registers; both stages hold while the output is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            g_q         <= '0;
            p_q         <= '0;
            v_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else if (adv) begin
            s1_vld_q    <= in_hs;
            out_valid_q <= s1_vld_q;
            if (in_hs) begin
                g_q <= g_nxt;
                p_q <= p_nxt;
                v_q <= v_nxt;
            end
            if (s1_vld_q) begin
                sum_q <= sum_nxt;
            end
        end
    end

endmodule
